// File: rtl/breath_pwm_multi.sv
// breath_pwm_multi: several breathing-LED PWM channels that share one
// triangle brightness ramp.
//
// A prescaler divides clk into PWM ticks, a phase counter splits ticks into
// frames, and the ramp level steps once per frame: 0..STEPS..0.
// Each channel picks one of four modes: off, solid, breathe, or inverted
// breathe. The resulting duty is latched only at frame boundaries, so a
// PWM frame is never cut short.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   en           global enable; low synchronously returns to the reset state
//   mode         per-channel mode, [2i+1:2i] for channel i
//                (00 off, 01 solid, 10 breathe, 11 inverted breathe)
//   pwm          registered PWM outputs, one per channel
//   level        current shared ramp level, 0..STEPS
//   breath_done  one-cycle pulse after the frame where the ramp falls to 0
module breath_pwm_multi #(
    parameter int unsigned CH    = 4,
    parameter int unsigned DIV   = 50,
    parameter int unsigned STEPS = 1000,
    localparam int unsigned LW   = $clog2(STEPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2*CH-1:0]   mode,
    output logic [CH-1:0]     pwm,
    output logic [LW-1:0]     level,
    output logic              breath_done
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [LW-1:0] STEPS_L  = LW'(STEPS);
    localparam logic [LW-1:0] PH_LAST  = LW'(STEPS - 1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PW-1:0] pre_q, pre_d;
    logic [LW-1:0] ph_q, ph_d;
    logic [LW-1:0] level_q, level_d;
    dir_e          dir_q, dir_d;
    logic          done_q, done_d;
    logic [CH-1:0] pwm_q, pwm_d;

    logic tick_c;
    logic frame_end_c;

    // Prescaler and frame phase counter
    always_comb begin
        pre_d       = pre_q;
        ph_d        = ph_q;
        tick_c      = (pre_q == PRE_LAST);
        frame_end_c = tick_c && (ph_q == PH_LAST);

        if (!en) begin
            pre_d = '0;
            ph_d  = '0;
        end else begin
            if (tick_c) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + PRE_ONE;
            end

            if (frame_end_c) begin
                ph_d = '0;
            end else if (tick_c) begin
                ph_d = ph_q + LVL_ONE;
            end
        end
    end

    // Ramp direction FSM: next state and level, stepped once per frame.
    // Turnarounds jump straight to STEPS-1 / 1 so the end levels last one
    // frame, like every other level.
    always_comb begin
        dir_d   = dir_q;
        level_d = level_q;
        done_d  = 1'b0;

        if (!en) begin
            dir_d   = DIR_UP;
            level_d = '0;
        end else if (frame_end_c) begin
            case (dir_q)
                DIR_UP: begin
                    if (level_q == STEPS_L) begin
                        dir_d   = DIR_DOWN;
                        level_d = STEPS_L - LVL_ONE;
                    end else begin
                        level_d = level_q + LVL_ONE;
                    end
                end
                DIR_DOWN: begin
                    if (level_q == '0) begin
                        dir_d   = DIR_UP;
                        level_d = LVL_ONE;
                    end else begin
                        level_d = level_q - LVL_ONE;
                        // A breath ends when the falling ramp reaches 0
                        done_d  = (level_q == LVL_ONE);
                    end
                end
                default: begin
                    dir_d   = DIR_UP;
                    level_d = '0;
                end
            endcase
        end
    end

    // Per-channel duty selection, frame-aligned latch, and PWM compare
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [LW-1:0] tgt_c;
        logic [LW-1:0] duty_q, duty_d;

        // Target uses the post-update level so it matches the next frame
        always_comb begin
            tgt_c = '0;
            case (mode[2*gi +: 2])
                2'b00:   tgt_c = '0;
                2'b01:   tgt_c = STEPS_L;
                2'b10:   tgt_c = level_d;
                2'b11:   tgt_c = STEPS_L - level_d;
                default: tgt_c = '0;
            endcase

            duty_d = duty_q;
            if (!en) begin
                duty_d = '0;
            end else if (frame_end_c) begin
                duty_d = tgt_c;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty_q <= '0;
            end else begin
                duty_q <= duty_d;
            end
        end

        assign pwm_d[gi] = en && (ph_q < duty_q);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            ph_q    <= '0;
            level_q <= '0;
            dir_q   <= DIR_UP;
            done_q  <= 1'b0;
            pwm_q   <= '0;
        end else begin
            pre_q   <= pre_d;
            ph_q    <= ph_d;
            level_q <= level_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm         = pwm_q;
    assign level       = level_q;
    assign breath_done = done_q;

endmodule

// File: tb/tb_breath_pwm_multi.sv
// Bench for breath_pwm_multi: a DIV=2/STEPS=4 two-channel instance plus a
// DIV=1/STEPS=2 single-channel instance sharing clock, reset and enable.
module tb_breath_pwm_multi;

    localparam int unsigned CH    = 2;
    localparam int unsigned DIV   = 2;
    localparam int unsigned STEPS = 4;
    localparam int unsigned LW    = $clog2(STEPS + 1);
    localparam int unsigned LW1   = $clog2(2 + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [2*CH-1:0]   mode;
    logic [CH-1:0]     pwm;
    logic [LW-1:0]     level;
    logic              breath_done;

    logic [1:0]        mode1;
    logic [0:0]        pwm1;
    logic [LW1-1:0]    level1;
    logic              done1;

    breath_pwm_multi #(.CH(CH), .DIV(DIV), .STEPS(STEPS)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .pwm         (pwm),
        .level       (level),
        .breath_done (breath_done)
    );

    breath_pwm_multi #(.CH(1), .DIV(1), .STEPS(2)) u_d1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode1),
        .pwm         (pwm1),
        .level       (level1),
        .breath_done (done1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;   // 0: main instance, 1: DIV=1 instance
        int cyc;   // posedges since reset release
        int lvl;
        int pwm;
        int done;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cross one posedge and land on the following negedge
    task automatic adv();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset pwm", int'(pwm), 0);
        chk("reset level", int'(level), 0);
        chk("reset done", int'(breath_done), 0);
        chk("reset d1 level", int'(level1), 0);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    function automatic void add(input int sel, input int c, input int lvl,
                                input int p, input int d);
        vec_t v;
        v.sel  = sel;
        v.cyc  = c;
        v.lvl  = lvl;
        v.pwm  = p;
        v.done = d;
        vecs.push_back(v);
    endfunction

    initial begin
        int dc0;
        int dc1;
        int hi;

        // Main instance: ch0 breathe (bit0), ch1 inverted (bit1).
        // Frame = 8 clocks; frame_end on posedge 8n.
        add(0,   3, 0, 2'b00, 0);
        add(0,   7, 0, 2'b00, 0);
        add(0,   8, 1, 2'b00, 0);
        add(0,   9, 1, 2'b11, 0);
        add(0,  11, 1, 2'b10, 0);
        add(0,  15, 1, 2'b00, 0);
        add(0,  16, 2, 2'b00, 0);
        add(0,  20, 2, 2'b11, 0);
        add(0,  21, 2, 2'b00, 0);
        add(0,  25, 3, 2'b11, 0);
        add(0,  27, 3, 2'b01, 0);
        add(0,  30, 3, 2'b01, 0);
        add(0,  31, 3, 2'b00, 0);
        add(0,  33, 4, 2'b01, 0);
        add(0,  40, 3, 2'b01, 0);
        add(0,  41, 3, 2'b11, 0);
        add(0,  48, 2, 2'b00, 0);
        add(0,  56, 1, 2'b00, 0);
        add(0,  63, 1, 2'b00, 0);
        add(0,  64, 0, 2'b00, 1);
        add(0,  65, 0, 2'b10, 0);
        add(0,  72, 1, 2'b10, 0);
        add(0, 128, 0, 2'b00, 1);
        add(0, 129, 0, 2'b10, 0);
        // DIV=1, STEPS=2, solid: frame = 2 clocks
        add(1,   1, 0, 0, 0);
        add(1,   2, 1, 0, 0);
        add(1,   3, 1, 1, 0);
        add(1,   4, 2, 1, 0);
        add(1,   6, 1, 1, 0);
        add(1,   7, 1, 1, 0);
        add(1,   8, 0, 1, 1);
        add(1,   9, 0, 1, 0);
        add(1,  10, 1, 1, 0);

        en    = 1'b1;
        mode  = {2'b11, 2'b10};
        mode1 = 2'b01;
        do_reset();

        dc0 = 0;
        dc1 = 0;
        for (int c = 1; c <= 136; c++) begin
            adv();
            if (breath_done) dc0++;
            if (done1) dc1++;
            foreach (vecs[k]) begin
                if (vecs[k].cyc == cyc) begin
                    if (vecs[k].sel == 0) begin
                        chk($sformatf("main c%0d level", cyc), int'(level), vecs[k].lvl);
                        chk($sformatf("main c%0d pwm", cyc), int'(pwm), vecs[k].pwm);
                        chk($sformatf("main c%0d done", cyc), int'(breath_done), vecs[k].done);
                    end else begin
                        chk($sformatf("d1 c%0d level", cyc), int'(level1), vecs[k].lvl);
                        chk($sformatf("d1 c%0d pwm", cyc), int'(pwm1), vecs[k].pwm);
                        chk($sformatf("d1 c%0d done", cyc), int'(done1), vecs[k].done);
                    end
                end
            end
        end
        chk("main done high cycles", dc0, 2);
        chk("d1 done high cycles", dc1, 17);

        // Mode boundary: ch0 solid -> off mid-frame
        mode = {2'b00, 2'b01};
        do_reset();
        while (cyc < 4) adv();
        chk("first frame solid pwm", int'(pwm), 0);
        while (cyc < 8) adv();
        chk("solid c8 pwm", int'(pwm), 0);
        while (cyc < 12) adv();
        chk("solid c12 pwm", int'(pwm), 1);
        mode = {2'b00, 2'b00};
        hi = 0;
        while (cyc < 16) begin
            adv();
            if (pwm[0]) hi++;
        end
        chk("off rest-of-frame high", hi, 4);
        hi = 0;
        while (cyc < 32) begin
            adv();
            if (pwm != '0) hi++;
        end
        chk("off after boundary high", hi, 0);

        // Enable drop at level 3 mid-frame, then restart
        mode = {2'b11, 2'b10};
        do_reset();
        while (cyc < 27) adv();
        chk("pre-disable level", int'(level), 3);
        chk("pre-disable pwm", int'(pwm), 2'b01);
        en = 1'b0;
        adv();
        chk("disable pwm", int'(pwm), 0);
        chk("disable level", int'(level), 0);
        chk("disable done", int'(breath_done), 0);
        repeat (3) adv();
        chk("disabled level held", int'(level), 0);
        en  = 1'b1;
        cyc = 0;
        hi  = 0;
        while (cyc < 7) begin
            adv();
            if (pwm != '0) hi++;
        end
        chk("restart c7 level", int'(level), 0);
        adv();
        if (pwm != '0) hi++;
        chk("restart first frame pwm high", hi, 0);
        chk("restart c8 level", int'(level), 1);
        adv();
        chk("restart c9 pwm", int'(pwm), 2'b11);
        while (cyc < 16) adv();
        chk("restart c16 level", int'(level), 2);

        // Asynchronous reset between clock edges
        while (cyc < 20) adv();
        chk("pre-async pwm", int'(pwm), 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async pwm", int'(pwm), 0);
        chk("async level", int'(level), 0);
        chk("async d1 level", int'(level1), 0);
        chk("async d1 pwm", int'(pwm1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/breath_pwm_multi.md
# breath_pwm_multi

Multi-channel breathing-LED PWM generator that drives several LED outputs from one shared triangle brightness ramp. Each channel has its own mode: off, solid on, breathe, or breathe in anti-phase. Clock divide, PWM resolution and channel count are parameters. Direction reversal is explicit and glitch-free, duty updates land only on PWM frame boundaries, and a pulse marks the end of each complete breath for alarm/UI sequencing.

## Interface
- `CH`, default 4: number of PWM channels (≥1).
- `DIV`, default 50: clocks per PWM tick (≥1); 50 gives a 1 µs tick at 50 MHz.
- `STEPS`, default 1000: ticks per PWM frame, which is also the peak brightness level (≥2).
- `LW`: localparam, `$clog2(STEPS+1)`.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: global enable; low synchronously clears the block to its reset state.
- `mode` input 2*CH: per-channel mode, bits [2i+1:2i] for channel i. 00 off, 01 solid, 10 breathe, 11 breathe inverted.
- `pwm` output CH: registered PWM outputs.
- `level` output LW: current shared ramp level, 0..STEPS.
- `breath_done` output 1: one-cycle pulse at the end of each full breath.

## Operation
**Prescaler `pre`** (0..DIV-1)
- Increments every clock while en=1.
- `tick` = (pre==DIV-1); on tick, pre wraps to 0.

**Phase counter `ph`** (0..STEPS-1)
- Increments on tick.
- `frame_end` = tick && ph==STEPS-1; at frame_end, ph wraps to 0.

**Ramp** (`level`, `dir`; dir 0=up, 1=down). Updates only on frame_end:
- up, level<STEPS: level+1.
- up, level==STEPS: dir=down, level=STEPS-1.
- down, level>0: level-1.
- down, level==0: dir=up, level=1.
- Resulting sequence: 0,1,…,STEPS,STEPS-1,…,1,0,1,…
- Breath period is 2*STEPS frames. Each level, including 0 and STEPS, lasts exactly one frame per pass.

**Per-channel target duty** (combinational from mode and level):
- 00 → 0
- 01 → STEPS
- 10 → level
- 11 → STEPS-level

**Duty latch**
- `duty_q[i]` loads the target duty on frame_end only.
- It uses the level value *after* that frame_end's update, so the duty applies to the frame that starts next.
- Mode changes mid-frame therefore take effect at the next frame boundary; no partial-frame glitches.

**PWM output**
- pwm[i] <= en && (ph < duty_q[i]), registered every clock.
- Duty 0 gives constant low. Duty STEPS gives constant high.

**breath_done**
- Registered pulse, high for one cycle after the frame_end on which dir==down and level goes 1→0.

**en=0**
- Synchronously forces pre=0, ph=0, level=0, dir=up, duty_q=0, pwm=0, breath_done=0.
- On en rising, counting starts fresh from pre=0.

**Arithmetic**
- All counters are unsigned.
- STEPS-level never underflows because level≤STEPS.
- DIV=1 gives tick every clock.

## Timing
- Reset values: pwm=0, level=0, breath_done=0; internal pre=0, ph=0, dir=up, duty_q=0.
- Frame length: DIV*STEPS clocks.
- Breath period: 2*STEPS*DIV*STEPS clocks (defaults: 1e8 clocks = 2 s at 50 MHz).
- First frame after reset or en rise: all pwm=0, including solid channels. Duties load at the first frame_end.
- pwm latency: one clock after ph/duty_q. Each frame's high run starts the clock after ph becomes 0 and lasts duty*DIV clocks.
- level and duty_q change on the same clock edge, at frame_end.
- breath_done asserts the clock after that frame_end and lasts exactly one clock.
- Async reset mid-frame clears all state immediately. Removal is synchronous to clk.
- en deassert mid-frame: pwm goes low on the next edge.

## Test plan
- Reset values: DIV=2, STEPS=4, CH=2, mode=10 on both, hold rst_n low → pwm=0, level=0. After release, level follows 0,1,2,3,4,3,2,1,0,1 at 8-clock frame intervals.
- PWM duty (same params): in the frame with level=3, the mode 10 channel is high for 6 clocks and low for 2. The mode 11 channel is high for 2 and low for 6.
- breath_done: pulses once per 64 clocks, one cycle wide, on the frame where level reaches 0 going down. No pulse at level=STEPS.
- Mode boundary: switch a channel 01→00 mid-frame → pwm stays high until the frame boundary, then stays constant 0. The first frame after reset is all 0 even for mode 01.
- Enable: deassert en at level=3 mid-frame → pwm=0 on the next clock and level=0. Reassert → ramp restarts 0,1,2… and the first frame_end comes after 8 clocks.
- Defaults smoke test: DIV=50, STEPS=1000 → frame_end every 50000 clocks. level reaches 1000 after 1000 frames, and breath_done period is 1e8 clocks.
